// File: rtl/brq_pkg.sv
// Shared constants and CSR address map for the BRQ hardware performance monitor.
package brq_pkg;

   localparam int unsigned HPM_FIRST_IDX    = 3;
   localparam int unsigned HPM_MAX_COUNTERS = 29;
   localparam int unsigned HPM_MAX_WIDTH    = 64;

   typedef enum logic [11:0] {
      CSR_MCOUNTINHIBIT  = 12'h320,
      CSR_MHPMEVENT3     = 12'h323,
      CSR_MHPMEVENT31    = 12'h33F,
      CSR_MHPMCOUNTER3   = 12'hB03,
      CSR_MHPMCOUNTER31  = 12'hB1F,
      CSR_MHPMCOUNTER3H  = 12'hB83,
      CSR_MHPMCOUNTER31H = 12'hB9F
   } csr_num_e;

   // True when addr lies in the inclusive range [first, last] of the CSR map.
   function automatic logic csrInRange(input logic [11:0] addr, input csr_num_e first,
                                       input csr_num_e last);
      return (addr >= first) && (addr <= last);
   endfunction

endpackage

// File: rtl/brq_hpm_counter.sv
// One width-parametrised HPM counter with half-word CSR writes, single-step
// increment and a sticky wrap flag.
module brq_hpm_counter
   import brq_pkg::*;
#(
   parameter int unsigned Width = 40
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             we_lo_i,
   input  logic             we_hi_i,
   input  logic [31:0]      wdata_i,
   output logic [Width-1:0] count_o,
   output logic             ovf_o
);

   if ((Width < 1) || (Width > HPM_MAX_WIDTH)) begin : gen_bad_width
      $fatal(1, "brq_hpm_counter: Width must be 1..64");
   end

   logic [Width-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [Width:0]   sum;

   // A software write beats the increment and clears the flag; otherwise a
   // single full-width add lets the carry ripple across the 32-bit halves.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      sum     = {1'b0, count_q} + {{Width{1'b0}}, 1'b1};
      if (we_lo_i || we_hi_i) begin
         for (int b = 0; b < Width; b++) begin
            if ((b < 32) ? we_lo_i : we_hi_i) begin
               count_d[b] = wdata_i[b % 32];
            end
         end
         ovf_d = 1'b0;
      end else if (inc_i) begin
         count_d = sum[Width-1:0];
         if (sum[Width]) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Counter and overflow state, cleared by the synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/brq_hpm_counter_bank.sv
// Bank of machine-mode HPM counters 3..3+NumCounters-1 with event selectors,
// inhibit bits, CSR read/write access and an overflow interrupt.
module brq_hpm_counter_bank
   import brq_pkg::*;
#(
   parameter int unsigned NumCounters  = 10,
   parameter int unsigned CounterWidth = 40,
   parameter int unsigned NumEvents    = 16,
   localparam int unsigned OvfWidth    = (NumCounters > 0) ? NumCounters : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NumEvents-1:0] events_i,
   input  logic [11:0]          csr_addr_i,
   input  logic                 csr_we_i,
   input  logic [31:0]          csr_wdata_i,
   output logic [31:0]          csr_rdata_o,
   output logic                 csr_hit_o,
   output logic [OvfWidth-1:0]  ovf_o,
   output logic                 irq_o
);

   if (NumCounters > HPM_MAX_COUNTERS) begin : gen_bad_count
      $fatal(1, "brq_hpm_counter_bank: NumCounters must be 0..29");
   end
   if ((CounterWidth < 1) || (CounterWidth > HPM_MAX_WIDTH)) begin : gen_bad_width
      $fatal(1, "brq_hpm_counter_bank: CounterWidth must be 1..64");
   end
   if ((NumEvents < 1) || (NumEvents > 32)) begin : gen_bad_events
      $fatal(1, "brq_hpm_counter_bank: NumEvents must be 1..32");
   end

   logic [OvfWidth-1:0]     inhibit_q, inhibit_d;
   logic [NumEvents-1:0]    mask_q [OvfWidth];
   logic [NumEvents-1:0]    mask_d [OvfWidth];
   logic [CounterWidth-1:0] count [OvfWidth];
   logic [OvfWidth-1:0]     incr, weLo, weHi, ovf;
   logic                    isInhibit, isEvent, isCntLo, isCntHi;
   int                      selIdx;

   // Classify the address; the low five bits give the CSR index k.
   always_comb begin
      isInhibit = (csr_addr_i == CSR_MCOUNTINHIBIT);
      isEvent   = csrInRange(csr_addr_i, CSR_MHPMEVENT3, CSR_MHPMEVENT31);
      isCntLo   = csrInRange(csr_addr_i, CSR_MHPMCOUNTER3, CSR_MHPMCOUNTER31);
      isCntHi   = csrInRange(csr_addr_i, CSR_MHPMCOUNTER3H, CSR_MHPMCOUNTER31H);
      selIdx    = int'(csr_addr_i[4:0]) - int'(HPM_FIRST_IDX);
      csr_hit_o = isInhibit | isEvent | isCntLo | isCntHi;
   end

   // Write decode: only implemented counters respond, others silently drop.
   always_comb begin
      inhibit_d = inhibit_q;
      mask_d    = mask_q;
      weLo      = '0;
      weHi      = '0;
      for (int j = 0; j < NumCounters; j++) begin
         if (csr_we_i && isInhibit) begin
            inhibit_d[j] = csr_wdata_i[HPM_FIRST_IDX + j];
         end
         if (selIdx == j) begin
            if (csr_we_i && isEvent) begin
               mask_d[j] = csr_wdata_i[NumEvents-1:0];
            end
            weLo[j] = csr_we_i && isCntLo;
            weHi[j] = csr_we_i && isCntHi;
         end
      end
   end

   // Increment requests use the registered inhibit and mask, so a write to
   // either only takes effect from the following cycle.
   always_comb begin
      incr = '0;
      for (int j = 0; j < NumCounters; j++) begin
         incr[j] = !inhibit_q[j] && (|(mask_q[j] & events_i));
      end
   end

   // Inhibit bits and event selectors.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         inhibit_q <= '0;
         mask_q    <= '{default: '0};
      end else begin
         inhibit_q <= inhibit_d;
         mask_q    <= mask_d;
      end
   end

   // Read mux: unimplemented bits and unimplemented indices return zero.
   always_comb begin
      csr_rdata_o = '0;
      for (int j = 0; j < NumCounters; j++) begin
         if (isInhibit) begin
            csr_rdata_o[HPM_FIRST_IDX + j] = inhibit_q[j];
         end
         if (selIdx == j) begin
            if (isEvent) begin
               for (int e = 0; e < NumEvents; e++) begin
                  csr_rdata_o[e] = mask_q[j][e];
               end
            end
            if (isCntLo) begin
               for (int b = 0; (b < CounterWidth) && (b < 32); b++) begin
                  csr_rdata_o[b] = count[j][b];
               end
            end
            if (isCntHi) begin
               for (int b = 32; b < CounterWidth; b++) begin
                  csr_rdata_o[b-32] = count[j][b];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < OvfWidth; g++) begin : gen_cnt
      if (g < NumCounters) begin : gen_impl
         brq_hpm_counter #(
            .Width (CounterWidth)
         ) u_counter (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc_i   (incr[g]),
            .we_lo_i (weLo[g]),
            .we_hi_i (weHi[g]),
            .wdata_i (csr_wdata_i),
            .count_o (count[g]),
            .ovf_o   (ovf[g])
         );
      end else begin : gen_none
         assign count[g] = '0;
         assign ovf[g]   = 1'b0;
      end
   end

   assign ovf_o = ovf;
   assign irq_o = |ovf;

endmodule

// File: tb/tb_brq_hpm_counter_bank.sv
// Self-checking bench for brq_hpm_counter_bank with default parameters.
module tb_brq_hpm_counter_bank;

   localparam int NC    = 10;
   localparam int NE    = 16;
   localparam int FIRST = 3;
   localparam longint unsigned CNT_MAX  = (64'd1 << 40) - 64'd1;
   localparam logic [31:0]     INH_IMPL = 32'h0000_1FF8;

   typedef struct {
      logic [11:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [15:0] ev;
      logic [11:0] rdAddr;
      logic [31:0] expData;
      logic        expHit;
      logic [9:0]  expOvf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic [15:0] events;
   logic [11:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;
   logic [9:0]  ovf;
   logic        irq;

   int checks = 0;
   int errors = 0;

   longint unsigned mCnt [32];
   logic [31:0]     mMask [32];
   logic [31:0]     mInh;
   logic [31:0]     mOvf;

   vec_t vecs [22];

   brq_hpm_counter_bank #(
      .NumCounters  (NC),
      .CounterWidth (40),
      .NumEvents    (NE)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .events_i    (events),
      .csr_addr_i  (addr),
      .csr_we_i    (we),
      .csr_wdata_i (wdata),
      .csr_rdata_o (rdata),
      .csr_hit_o   (hit),
      .ovf_o       (ovf),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;

   // Reference model: counters as plain integers wrapping at 2^40.
   function automatic void modelReset();
      for (int i = 0; i < 32; i++) begin
         mCnt[i]  = 0;
         mMask[i] = '0;
      end
      mInh = '0;
      mOvf = '0;
   endfunction

   function automatic void modelRead(input logic [11:0] a, output logic h, output logic [31:0] d);
      int  k;
      logic impl;
      k    = int'(a[4:0]);
      impl = (k >= FIRST) && (k < FIRST + NC);
      h = 1'b0;
      d = '0;
      if (a == 12'h320) begin
         h = 1'b1;
         d = mInh;
      end else if (a >= 12'h323 && a <= 12'h33F) begin
         h = 1'b1;
         if (impl) d = mMask[k];
      end else if (a >= 12'hB03 && a <= 12'hB1F) begin
         h = 1'b1;
         if (impl) d = 32'(mCnt[k] % 64'h1_0000_0000);
      end else if (a >= 12'hB83 && a <= 12'hB9F) begin
         h = 1'b1;
         if (impl) d = 32'(mCnt[k] / 64'h1_0000_0000);
      end
   endfunction

   function automatic void modelStep(input logic [11:0] a, input logic w, input logic [31:0] d,
                                     input logic [15:0] e);
      int          k;
      logic [31:0] incV;
      logic        wrLo, wrHi;
      k    = int'(a[4:0]);
      incV = '0;
      for (int i = FIRST; i < FIRST + NC; i++) begin
         incV[i] = !mInh[i] && ((mMask[i][15:0] & e) != 16'h0);
      end
      for (int i = FIRST; i < FIRST + NC; i++) begin
         wrLo = w && (a >= 12'hB03) && (a <= 12'hB1F) && (k == i);
         wrHi = w && (a >= 12'hB83) && (a <= 12'hB9F) && (k == i);
         if (wrLo) begin
            mCnt[i] = (mCnt[i] / 64'h1_0000_0000) * 64'h1_0000_0000 + 64'(d);
            mOvf[i] = 1'b0;
         end else if (wrHi) begin
            mCnt[i] = (mCnt[i] % 64'h1_0000_0000) + (64'(d) % 64'h100) * 64'h1_0000_0000;
            mOvf[i] = 1'b0;
         end else if (incV[i]) begin
            if (mCnt[i] == CNT_MAX) begin
               mCnt[i] = 0;
               mOvf[i] = 1'b1;
            end else begin
               mCnt[i] = mCnt[i] + 1;
            end
         end
      end
      if (w && a == 12'h320) mInh = d & INH_IMPL;
      if (w && a >= 12'h323 && a <= 12'h33F && k >= FIRST && k < FIRST + NC) begin
         mMask[k] = d & 32'h0000_FFFF;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and compare the pre-edge
   // combinational view against the model.
   task automatic applyStimulus(input logic [11:0] a, input logic w, input logic [31:0] d,
                                input logic [15:0] e);
      logic        expHit;
      logic [31:0] expData;
      @(negedge clk);
      addr   = a;
      we     = w;
      wdata  = d;
      events = e;
      #1;
      modelRead(a, expHit, expData);
      checkOutput($sformatf("model rdata @%03h", a), rdata, expData);
      checkOutput($sformatf("model hit @%03h", a), 32'(hit), 32'(expHit));
      checkOutput("model ovf", 32'(ovf), 32'(mOvf[12:3]));
      checkOutput("model irq", 32'(irq), 32'(mOvf[12:3] != 10'h0));
   endtask

   // Let the rising edge happen and advance the model accordingly.
   task automatic advance();
      @(posedge clk);
      if (!rstN) modelReset();
      else modelStep(addr, we, wdata, events);
      #1;
   endtask

   initial begin
      vecs[0]  = '{12'hB03, 1'b1, 32'hFFFF_FFFF, 16'h0, 12'hB03, 32'hFFFF_FFFF, 1'b1, 10'h0};
      vecs[1]  = '{12'hB83, 1'b1, 32'h0,         16'h0, 12'hB83, 32'h0,         1'b1, 10'h0};
      vecs[2]  = '{12'h323, 1'b1, 32'h1,         16'h0, 12'h323, 32'h1,         1'b1, 10'h0};
      vecs[3]  = '{12'h000, 1'b0, 32'h0,         16'h1, 12'hB03, 32'h0,         1'b1, 10'h0};
      vecs[4]  = '{12'h000, 1'b0, 32'h0,         16'h0, 12'hB83, 32'h1,         1'b1, 10'h0};
      vecs[5]  = '{12'hB83, 1'b1, 32'hFF,        16'h0, 12'hB83, 32'hFF,        1'b1, 10'h0};
      vecs[6]  = '{12'hB03, 1'b1, 32'hFFFF_FFFF, 16'h0, 12'hB03, 32'hFFFF_FFFF, 1'b1, 10'h0};
      vecs[7]  = '{12'h000, 1'b0, 32'h0,         16'h1, 12'hB03, 32'h0,         1'b1, 10'h1};
      vecs[8]  = '{12'h000, 1'b0, 32'h0,         16'h0, 12'hB83, 32'h0,         1'b1, 10'h1};
      vecs[9]  = '{12'hB83, 1'b1, 32'h0,         16'h0, 12'hB83, 32'h0,         1'b1, 10'h0};
      vecs[10] = '{12'hB03, 1'b1, 32'h5,         16'h0, 12'hB03, 32'h5,         1'b1, 10'h0};
      vecs[11] = '{12'hB03, 1'b1, 32'h100,       16'h1, 12'hB03, 32'h100,       1'b1, 10'h0};
      vecs[12] = '{12'h320, 1'b1, 32'h8,         16'h1, 12'hB03, 32'h101,       1'b1, 10'h0};
      vecs[13] = '{12'h000, 1'b0, 32'h0,         16'h1, 12'hB03, 32'h101,       1'b1, 10'h0};
      vecs[14] = '{12'h000, 1'b0, 32'h0,         16'h0, 12'h320, 32'h8,         1'b1, 10'h0};
      vecs[15] = '{12'h000, 1'b0, 32'h0,         16'h0, 12'hB10, 32'h0,         1'b1, 10'h0};
      vecs[16] = '{12'hB10, 1'b1, 32'hFFFF_FFFF, 16'h0, 12'hB10, 32'h0,         1'b1, 10'h0};
      vecs[17] = '{12'h320, 1'b1, 32'hFFFF_FFFF, 16'h0, 12'h320, 32'h1FF8,      1'b1, 10'h0};
      vecs[18] = '{12'h000, 1'b0, 32'h0,         16'h0, 12'h7A0, 32'h0,         1'b0, 10'h0};
      vecs[19] = '{12'h320, 1'b1, 32'h0,         16'h0, 12'h33F, 32'h0,         1'b1, 10'h0};
      vecs[20] = '{12'h324, 1'b1, 32'hFFFF_FFFF, 16'h0, 12'h324, 32'hFFFF,      1'b1, 10'h0};
      vecs[21] = '{12'h000, 1'b0, 32'h0,         16'h0, 12'h321, 32'h0,         1'b0, 10'h0};

      rstN   = 1'b0;
      addr   = '0;
      we     = 1'b0;
      wdata  = '0;
      events = '0;
      modelReset();
      advance();
      advance();
      rstN = 1'b1;

      // Reset state.
      applyStimulus(12'hB03, 1'b0, 32'h0, 16'h0);
      checkOutput("reset ctr3 low", rdata, 32'h0);
      checkOutput("reset irq", 32'(irq), 32'h0);
      advance();

      $display("[TB] directed vectors");
      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].ev);
         advance();
         applyStimulus(vecs[i].rdAddr, 1'b0, 32'h0, 16'h0);
         checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expData);
         checkOutput($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].expHit));
         checkOutput($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].expOvf));
         checkOutput($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].expOvf != 10'h0));
         advance();
      end

      $display("[TB] reset during counting with a pending write");
      applyStimulus(12'hB83, 1'b1, 32'hFF, 16'h0);
      advance();
      applyStimulus(12'hB03, 1'b1, 32'hFFFF_FFFF, 16'h0);
      advance();
      applyStimulus(12'h000, 1'b0, 32'h0, 16'h1);
      advance();
      applyStimulus(12'hB03, 1'b0, 32'h0, 16'h0);
      checkOutput("pre-reset irq", 32'(irq), 32'h1);
      advance();
      @(negedge clk);
      rstN   = 1'b0;
      addr   = 12'hB03;
      we     = 1'b1;
      wdata  = 32'h1234;
      events = 16'hFFFF;
      advance();
      rstN = 1'b1;
      applyStimulus(12'hB03, 1'b0, 32'h0, 16'h0);
      checkOutput("post-reset ctr3", rdata, 32'h0);
      checkOutput("post-reset ovf", 32'(ovf), 32'h0);
      checkOutput("post-reset irq", 32'(irq), 32'h0);
      advance();
      applyStimulus(12'h323, 1'b0, 32'h0, 16'h0);
      checkOutput("post-reset mask3", rdata, 32'h0);
      advance();
      applyStimulus(12'h320, 1'b0, 32'h0, 16'h0);
      checkOutput("post-reset inhibit", rdata, 32'h0);
      advance();
      applyStimulus(12'h323, 1'b1, 32'h1, 16'h0);
      advance();
      applyStimulus(12'h000, 1'b0, 32'h0, 16'h1);
      advance();
      applyStimulus(12'hB03, 1'b0, 32'h0, 16'h0);
      checkOutput("count after reset", rdata, 32'h1);
      advance();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 800; n++) begin
         logic [11:0] a;
         logic [31:0] d;
         int          k;
         int          sel;
         k   = $urandom_range(3, 15);
         sel = $urandom_range(0, 9);
         d   = $urandom;
         case (sel)
            0, 1, 2: begin
               a = 12'hB00 + 12'(k);
               if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            end
            3, 4: begin
               a = 12'hB80 + 12'(k);
               if ($urandom_range(0, 1) == 1) d = 32'hFF;
            end
            5, 6: a = 12'h320 + 12'(k);
            7: begin
               a = 12'h320;
               if ($urandom_range(0, 2) != 0) d = 32'h0;
            end
            8: a = 12'($urandom);
            default: a = ($urandom_range(0, 1) == 1) ? 12'hB1F : 12'hB9F;
         endcase
         applyStimulus(a, ($urandom_range(0, 3) == 0), d,
                       ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/brq_hpm_counter_bank.md
BRQ_HPM_COUNTER_BANK -- requirements
Module: brq_hpm_counter_bank

Interface
REQ-001 SHALL have parameter NumCounters, default 10, number of implemented HPM counters (legal 0..29), mapped to indices 3..3+NumCounters-1.
REQ-002 SHALL have parameter CounterWidth, default 40, implemented bits per counter (legal 1..64).
REQ-003 SHALL have parameter NumEvents, default 16, number of event inputs (legal 1..32).
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk_i in 1 clock; rst_ni in 1 reset, sampled only on rising clk_i.
REQ-005 events_i  in  NumEvents  one-cycle event strobes, any number high per cycle.
REQ-006 csr_addr_i  in  12  CSR address (csr_num_e encoding).
REQ-007 csr_we_i  in  1  write strobe, full-word write of csr_wdata_i.
REQ-008 csr_wdata_i  in  32  write data.
REQ-009 csr_rdata_o  out  32  read data for csr_addr_i, combinational from registers.
REQ-010 csr_hit_o  out  1  high when csr_addr_i is in this block's address set.
REQ-011 ovf_o  out  NumCounters  sticky per-counter overflow flags.
REQ-012 irq_o  out  1  OR of ovf_o.

Function
REQ-013 Address set SHALL be MHPMCOUNTERk (0xB03-0xB1F), MHPMCOUNTERkH (0xB83-0xB9F), MHPMEVENTk (0x323-0x33F) for k=3..31, plus MCOUNTINHIBIT (0x320); csr_hit_o high for all, low otherwise with csr_rdata_o=0.
REQ-014 Indices k >= 3+NumCounters SHALL read 0 and ignore writes; csr_hit_o still high.
REQ-015 MCOUNTINHIBIT SHALL implement bits [3+NumCounters-1:3] only; all other bits read 0.
REQ-016 MHPMEVENTk SHALL hold a NumEvents-bit select mask in bits [NumEvents-1:0]; upper bits read 0, writes to them ignored.
REQ-017 Counter k SHALL increment by exactly 1 on the next rising edge when inhibit[k]=0 and |(mask[k] & events_i)=1; multiple matching events in one cycle still give +1.
REQ-018 Increment decision SHALL use the inhibit and mask register values held at the start of the cycle; a same-cycle write to MCOUNTINHIBIT/MHPMEVENTk affects the following cycle only.
REQ-019 Low read SHALL return counter[min(W,32)-1:0] zero-extended; high read SHALL return counter[W-1:32] zero-extended when W>32, else 0.
REQ-020 A write to low or high half SHALL update only the implemented bits of that half; the other half retains its pre-edge value.
REQ-021 A write to counter k SHALL take priority over that cycle's increment of counter k (increment lost, no carry).
REQ-022 Increment of a counter at all-ones (W bits) SHALL wrap to 0 and set ovf_o[k] at the same edge.
REQ-023 ovf_o[k] SHALL stay set until a write to MHPMCOUNTERk or MHPMCOUNTERkH clears it; simultaneous wrap and write: write wins, flag clears.
REQ-024 Carry from bit 31 to bit 32 SHALL occur within the same increment (single W-bit adder).
REQ-025 irq_o SHALL be combinational OR of ovf_o registers; no additional latency.

Reset
REQ-026 On rising clk_i with rst_ni=0: all counters 0, all masks 0, MCOUNTINHIBIT 0, ovf_o 0, irq_o 0; csr_rdata_o 0 for every address thereafter until written.
REQ-027 Reset SHALL override any same-cycle write or increment.
REQ-028 Reset deassertion SHALL allow counting from the first following edge.

Structure
REQ-029 brq_pkg SHALL gain HPM_FIRST_IDX=3, HPM_MAX_COUNTERS=29 and HPM_MAX_WIDTH=64; CSR addresses SHALL come from csr_num_e.
REQ-030 One sub-module brq_hpm_counter (width-parametrised counter with write/increment/overflow) SHALL be instantiated NumCounters times via generate.
REQ-031 Parameter legality SHALL be checked with elaboration-time assertions.

Verification
REQ-032 W=40: write 0xFFFFFFFF to 0xB03, 0x00 to 0xB83, mask[3]=1, pulse events_i[0] once -> low reads 0, high reads 1, ovf_o[0]=0.
REQ-033 W=40: counter3=0xFF_FFFFFFFF, one event -> counter 0, ovf_o[0]=1, irq_o=1; write 0 to 0xB83 -> ovf_o[0]=0, irq_o=0.
REQ-034 Counter3=5, event and write 0x100 to 0xB03 same cycle -> reads 0x100, not 0x101.
REQ-035 Write MCOUNTINHIBIT=0x8 with event same cycle -> counter3 increments once; events next cycle -> no further increment.
REQ-036 NumCounters=10: read 0xB10 (k=16) -> 0, csr_hit_o=1; write 0xFFFFFFFF to 0x320 then read -> 0x00001FF8; read 0x7A0 -> csr_hit_o=0.
REQ-037 Assert rst_ni=0 mid-counting with pending write -> all counters, masks, ovf_o read 0 after the edge.
